// File: rtl/cpu_pkg.sv
`default_nettype none
// ==========================================================================
// cpu_pkg : shared fetch constants and fetch-state encoding.  Rev 1.0
// ==========================================================================
package cpu_pkg;

   localparam logic [3:0]  HALT_OPCODE  = 4'b1111;
   localparam logic [15:0] NOP_INSTR    = 16'h0000;
   localparam int          INSTR_STRIDE = 4;
   localparam int          IMEM_DEPTH   = 128;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ==========================================================================
// instruction_fetch_unit_if : memory, redirect and IF/ID bundle.  Rev 1.0
// ==========================================================================
interface instruction_fetch_unit_if;

   logic [15:0] PCAddress;
   logic [15:0] Instruction;
   logic        Redirect;
   logic [15:0] RedirectTarget;
   logic        DecodeReady;
   logic [15:0] IFID_Instruction;
   logic [15:0] IFID_PC;
   logic        IFID_Valid;
   logic        Halted;
   logic [15:0] FetchCount;

   modport master (
      output PCAddress,
      input  Instruction,
      input  Redirect,
      input  RedirectTarget,
      input  DecodeReady,
      output IFID_Instruction,
      output IFID_PC,
      output IFID_Valid,
      output Halted,
      output FetchCount
   );

   modport slave (
      input  PCAddress,
      output Instruction,
      output Redirect,
      output RedirectTarget,
      output DecodeReady,
      input  IFID_Instruction,
      input  IFID_PC,
      input  IFID_Valid,
      input  Halted,
      input  FetchCount
   );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_next.sv
`default_nettype none
// ==========================================================================
// pc_next_logic : next-PC selection with alignment and depth wrap.  Rev 1.0
// ==========================================================================
module pc_next_logic #(
   parameter int STRIDE = 4,
   parameter int DEPTH  = 128
) (
   input  logic [15:0] pc_i,
   input  logic        redirect_i,
   input  logic [15:0] target_i,
   input  logic        advance_i,
   output logic [15:0] pc_next_o
);

   localparam logic [15:0] STEP       = 16'(STRIDE);
   localparam logic [15:0] ALIGN_MASK = ~(16'(STRIDE) - 16'd1);
   localparam logic [15:0] DEPTH_MASK = 16'(DEPTH) - 16'd1;

   always_comb begin
      pc_next_o = pc_i;
      if (redirect_i) begin
         pc_next_o = target_i & ALIGN_MASK & DEPTH_MASK;
      end else if (advance_i) begin
         pc_next_o = (pc_i + STEP) & DEPTH_MASK;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ==========================================================================
// instruction_fetch_unit : PC, IF/ID register, HALT/redirect control.  Rev 1.0
// ==========================================================================
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC     = 16'd0,
   parameter int          IMEM_DEPTH   = cpu_pkg::IMEM_DEPTH,
   parameter int          INSTR_STRIDE = cpu_pkg::INSTR_STRIDE,
   parameter logic [3:0]  HALT_OPCODE  = cpu_pkg::HALT_OPCODE,
   parameter logic [15:0] NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
   input  logic                       Clock,
   input  logic                       Reset,
   instruction_fetch_unit_if.master   bus
);

   import cpu_pkg::*;

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  instr_q, instr_d;
   logic [15:0]  ifpc_q, ifpc_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         valid_q, valid_d;
   logic         load;
   logic         is_halt;
   logic         advance;

   assign load    = (state_q == RUN) && (!valid_q || bus.DecodeReady);
   assign is_halt = (bus.Instruction[15:12] == HALT_OPCODE);
   // A fetched HALT parks the PC on its own address.
   assign advance = load && !is_halt;

   pc_next_logic #(
      .STRIDE (INSTR_STRIDE),
      .DEPTH  (IMEM_DEPTH)
   ) u_pc_next (
      .pc_i       (pc_q),
      .redirect_i (bus.Redirect),
      .target_i   (bus.RedirectTarget),
      .advance_i  (advance),
      .pc_next_o  (pc_d)
   );

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (bus.Redirect) begin
         state_d = RUN;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = bus.Instruction;
         ifpc_d  = pc_q;
         valid_d = 1'b1;
         cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         if (is_halt) begin
            state_d = HALTED;
         end
      end else if (state_q == HALTED && valid_q && bus.DecodeReady) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ifpc_q  <= 16'd0;
         cnt_q   <= 16'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.PCAddress        = pc_q;
   assign bus.IFID_Instruction = instr_q;
   assign bus.IFID_PC          = ifpc_q;
   assign bus.IFID_Valid       = valid_q;
   assign bus.Halted           = (state_q == HALTED);
   assign bus.FetchCount       = cnt_q;

endmodule
`default_nettype wire
